// File: rtl/calcu_pkg.sv
// ----------------------------------------------------------------------------
// calcu_pkg
//   Shared definitions for the fetch stage and for its neighbours (decode and
//   debug reuse fetch_state_t to interpret the fetch state).
//   Contents:
//     ADDR_W         address / PC width
//     DATA_W         instruction word width
//     fetch_state_t  IDLE / REQ / FULL fetch states
// ----------------------------------------------------------------------------
package calcu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // latch the PC into the request address
        REQ  = 2'd1,   // memory read outstanding
        FULL = 2'd2    // fetched word held for decode
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_if
//   Bundles the PC, instruction-memory and decode-side signals of the fetch
//   stage.
//   Signals:
//     pc          PC value                       (PC    -> fetch)
//     pc_step     PC increment enable            (fetch -> PC)
//     flush       branch flush, PC loads target  (PC    -> fetch)
//     mem_req     read request                   (fetch -> memory)
//     mem_addr    read address                   (fetch -> memory)
//     mem_ack     read data valid                (memory -> fetch)
//     mem_rdata   read data                      (memory -> fetch)
//     instr       fetched word                   (fetch -> decode)
//     instr_pc    address of instr               (fetch -> decode)
//     instr_valid instr/instr_pc valid           (fetch -> decode)
//     instr_ready decode accepts                 (decode -> fetch)
//   Modports:
//     master  fetch-stage view
//     slave   environment view (PC, memory, decode)
// ----------------------------------------------------------------------------
interface instruction_fetch_if;
    import calcu_pkg::*;

    logic [ADDR_W-1:0] pc;
    logic              pc_step;
    logic              flush;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        input  pc, flush, mem_ack, mem_rdata, instr_ready,
        output pc_step, mem_req, mem_addr, instr, instr_pc, instr_valid
    );

    modport slave (
        output pc, flush, mem_ack, mem_rdata, instr_ready,
        input  pc_step, mem_req, mem_addr, instr, instr_pc, instr_valid
    );

endinterface

// File: rtl/fetch_stall_counter.sv
// ----------------------------------------------------------------------------
// fetch_stall_counter
//   Saturating up-counter of fetch stall cycles. Sticks at all-ones and is
//   cleared only by reset.
//   Parameters:
//     W        counter width
//   Ports:
//     clk      clock, posedge
//     reset    synchronous, active-high clear
//     inc_i    count this cycle
//     count_o  current count
// ----------------------------------------------------------------------------
module fetch_stall_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage sitting directly after the program counter. Samples the PC,
//   issues a single-word read to instruction memory and holds the returned
//   word for decode behind a valid/ready handshake. Drives pc_step (the PC's
//   increment enable) and abandons any in-flight or held word on flush.
//   Ports:
//     clk          clock, all state on posedge
//     reset        synchronous, active-high
//     bus          instruction_fetch_if.master (PC, memory and decode signals)
//     stall_count  saturating stall-cycle count (FETCH_STALL_CNT_EN only)
//   Configuration:
//     FETCH_STALL_CNT_EN  when defined, adds the STALL_CNT_W parameter, the
//                         stall_count port and the stall counter.
// ----------------------------------------------------------------------------
module instruction_fetch
    import calcu_pkg::*;
`ifdef FETCH_STALL_CNT_EN
#(
    parameter int STALL_CNT_W = 16
)
`endif
(
    input  logic                   clk,
    input  logic                   reset,
    instruction_fetch_if.master    bus
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_count
`endif
);

    fetch_state_t      state_q,    state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_W-1:0] instr_q,    instr_d;

    // Next-state logic. flush outranks everything except reset: whatever the
    // current state, the stage restarts from IDLE so the freshly loaded PC
    // target is the next address fetched. An ack in the flush cycle is dropped.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        instr_pc_d = instr_pc_q;
        instr_d    = instr_q;

        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    mem_addr_d = bus.pc;
                    state_d    = REQ;
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        instr_d    = bus.mem_rdata;
                        instr_pc_d = mem_addr_q;
                        state_d    = FULL;
                    end
                end
                FULL: begin
                    // The PC already advanced on the capture edge, so bus.pc
                    // is the next sequential address here.
                    if (bus.instr_ready) begin
                        mem_addr_d = bus.pc;
                        state_d    = REQ;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the datapath registers are cleared too, so decode and
            // debug see defined values instead of X straight out of reset.
            state_q    <= IDLE;
            mem_addr_q <= '0;
            instr_pc_q <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            instr_pc_q <= instr_pc_d;
            instr_q    <= instr_d;
        end
    end

    // The PC steps on the same edge that captures the word; a flushed ack
    // must not step because the PC is loading the branch target instead.
    assign bus.pc_step     = (state_q == REQ) & bus.mem_ack & ~bus.flush & ~reset;
    assign bus.mem_req     = (state_q == REQ);
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = (state_q == FULL);

`ifdef FETCH_STALL_CNT_EN
    // A stall is a cycle waiting on memory or on decode back-pressure.
    logic stall_inc;

    assign stall_inc = ((state_q == REQ)  & ~bus.mem_ack) |
                       ((state_q == FULL) & ~bus.instr_ready);

    fetch_stall_counter #(
        .W (STALL_CNT_W)
    ) u_stall_counter (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (stall_inc),
        .count_o (stall_count)
    );
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
//   Self-checking bench for instruction_fetch: directed steps followed by a
//   randomized phase in which the bench plays PC, memory and decode and checks
//   the consumed instruction stream against an address-sequence model.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instruction_fetch_if bus ();

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_count;
    logic        sat_inc;
    logic [2:0]  sat_count;

    fetch_stall_counter #(
        .W (3)
    ) u_sat (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (sat_inc),
        .count_o (sat_count)
    );
`endif

    instruction_fetch u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] flush_target;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory contents for the random phase: any fixed address->data mapping.
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Called at a negedge: advance one clock, then behave like the PC
    // (load target on flush, else increment on pc_step).
    task automatic tick();
        logic st;
        st = bus.pc_step;
        @(posedge clk);
        #1;
        if (bus.flush) bus.pc = flush_target;
        else if (st)   bus.pc = bus.pc + 16'd1;
    endtask

    initial begin
        logic [15:0] exp_pc;
        logic        prev_req, prev_ack, prev_flush, prev_valid, prev_ready;
        logic [15:0] prev_addr, prev_instr, prev_ipc;
        int          n_hs;

        bus.pc          = 16'h0000;
        bus.flush       = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = 16'h0000;
        bus.instr_ready = 1'b0;
        flush_target    = 16'h0000;
`ifdef FETCH_STALL_CNT_EN
        sat_inc         = 1'b0;
`endif
        reset           = 1'b1;

        // 1: reset for two cycles, then first request on the 2nd cycle.
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mem_req",     bus.mem_req,     0);
        check("rst_instr_valid", bus.instr_valid, 0);
        check("rst_instr",       bus.instr,       0);
        check("rst_instr_pc",    bus.instr_pc,    0);
        check("rst_mem_addr",    bus.mem_addr,    0);
        check("rst_pc_step",     bus.pc_step,     0);
`ifdef FETCH_STALL_CNT_EN
        check("rst_stall_count", stall_count,     0);
`endif
        tick();
        reset = 1'b0;

        @(negedge clk);
        check("idle_no_req", bus.mem_req, 0);
        tick();
        @(negedge clk);
        check("req1_mem_req",  bus.mem_req,  1);
        check("req1_mem_addr", bus.mem_addr, 16'h0000);
        check("wait1_pc_step", bus.pc_step,  0);
        tick();

        // 2: second wait cycle, then ack with 0xABCD.
        @(negedge clk);
        check("wait2_mem_req", bus.mem_req, 1);
        check("wait2_pc_step", bus.pc_step, 0);
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hABCD;
        @(negedge clk);
        check("ack_pc_step", bus.pc_step, 1);
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;

        // 3: five cycles of back-pressure, then handshake.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_instr",       bus.instr,       16'hABCD);
            check("bp_instr_pc",    bus.instr_pc,    16'h0000);
            check("bp_instr_valid", bus.instr_valid, 1);
            check("bp_mem_req",     bus.mem_req,     0);
            check("bp_pc_step",     bus.pc_step,     0);
            tick();
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        check("hs_valid", bus.instr_valid, 1);
        tick();
        bus.instr_ready = 1'b0;
        @(negedge clk);
        check("next_mem_req",  bus.mem_req,     1);
        check("next_mem_addr", bus.mem_addr,    16'h0001);
        check("next_valid",    bus.instr_valid, 0);
`ifdef FETCH_STALL_CNT_EN
        check("stall_count_7", stall_count, 7);
`endif
        tick();

        // 4: flush coinciding with ack; PC loads 0x0100.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        bus.flush     = 1'b1;
        flush_target  = 16'h0100;
        @(negedge clk);
        check("flush_pc_step", bus.pc_step, 0);
        tick();
        bus.mem_ack = 1'b0;
        bus.flush   = 1'b0;
        @(negedge clk);
        check("flush_valid",   bus.instr_valid, 0);
        check("flush_mem_req", bus.mem_req,     0);
        tick();
        @(negedge clk);
        check("refetch_mem_req",  bus.mem_req,  1);
        check("refetch_mem_addr", bus.mem_addr, 16'h0100);

        // 5: fetch from 0xFFFF; the next request wraps to 0x0000.
        bus.flush    = 1'b1;
        flush_target = 16'hFFFF;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        check("wrap_idle_req", bus.mem_req, 0);
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h1234;
        @(negedge clk);
        check("wrap_mem_addr", bus.mem_addr, 16'hFFFF);
        check("wrap_pc_step",  bus.pc_step,  1);
        tick();
        bus.mem_ack     = 1'b0;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        check("wrap_instr_pc", bus.instr_pc,    16'hFFFF);
        check("wrap_instr",    bus.instr,       16'h1234);
        check("wrap_valid",    bus.instr_valid, 1);
        tick();
        bus.instr_ready = 1'b0;
        @(negedge clk);
        check("wrap_next_req",  bus.mem_req,  1);
        check("wrap_next_addr", bus.mem_addr, 16'h0000);
        tick();

        // Random phase: instructions must be consumed at consecutive
        // addresses from the last flush target, with data from memory.
        exp_pc     = 16'h0000;
        n_hs       = 0;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_flush = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_addr  = '0;
        prev_instr = '0;
        prev_ipc   = '0;
        for (int c = 0; c < 400; c++) begin
            bus.mem_ack     = bus.mem_req && ($urandom_range(0, 1) == 1);
            bus.mem_rdata   = mem_f(bus.mem_addr);
            bus.instr_ready = ($urandom_range(0, 1) == 1);
            bus.flush       = ($urandom_range(0, 15) == 0);
            flush_target    = 16'($urandom);
            @(negedge clk);
            if (prev_req && !prev_ack && !prev_flush) begin
                check("rnd_req_held",  bus.mem_req,  1);
                check("rnd_addr_held", bus.mem_addr, prev_addr);
            end
            if (prev_valid && !prev_ready && !prev_flush) begin
                check("rnd_valid_held", bus.instr_valid, 1);
                check("rnd_instr_held", bus.instr,       prev_instr);
                check("rnd_ipc_held",   bus.instr_pc,    prev_ipc);
            end
            check("rnd_pc_step", bus.pc_step, bus.mem_req & bus.mem_ack & ~bus.flush);
            if (bus.instr_valid && bus.instr_ready) begin
                check("rnd_instr_pc", bus.instr_pc, exp_pc);
                check("rnd_instr",    bus.instr,    mem_f(exp_pc));
                exp_pc = exp_pc + 16'd1;
                n_hs++;
            end
            if (bus.flush) exp_pc = flush_target;
            prev_req   = bus.mem_req;
            prev_ack   = bus.mem_ack;
            prev_flush = bus.flush;
            prev_valid = bus.instr_valid;
            prev_ready = bus.instr_ready;
            prev_addr  = bus.mem_addr;
            prev_instr = bus.instr;
            prev_ipc   = bus.instr_pc;
            tick();
        end
        bus.flush       = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.instr_ready = 1'b0;
        check("rnd_progress", n_hs > 20, 1);

`ifdef FETCH_STALL_CNT_EN
        // 6: a 3-bit stall counter saturates at 7 and holds there.
        sat_inc = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            check("sat_count", sat_count, (i > 7) ? 7 : i);
        end
        sat_inc = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
